// File: rtl/traffic_pkg.sv
// rtl/traffic_pkg.sv - shared encodings and quantiser for the traffic density sensor
package traffic_pkg;

    typedef enum logic [1:0] {
        LVL_LOW  = 2'b00,
        LVL_MED  = 2'b01,
        LVL_HIGH = 2'b10,
        LVL_MAX  = 2'b11
    } level_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    function automatic level_t quantise(input int count, input int th1, input int th2, input int th3);
        if (count < th1) return LVL_LOW;
        if (count < th2) return LVL_MED;
        if (count < th3) return LVL_HIGH;
        return LVL_MAX;
    endfunction

endpackage

// File: rtl/lane_density_counter.sv
// rtl/lane_density_counter.sv - per-approach synchroniser, vehicle counter, stuck detector and quantiser
module lane_density_counter
    import traffic_pkg::*;
#(
    parameter int CNT_W        = 8,
    parameter int TH1          = 4,
    parameter int TH2          = 8,
    parameter int TH3          = 16,
    parameter int STUCK_CYCLES = 500
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   det,
    input  logic   active,
    input  logic   close,
    output level_t level,
    output logic   fault
);

    localparam int               STUCK_W   = $clog2(STUCK_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [STUCK_W-1:0] STUCK_MAX = STUCK_W'(STUCK_CYCLES);

    logic               sync_1;
    logic               sync_2;
    logic               sync_prev;
    logic               rise_q;
    logic               inc;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   closing_cnt;
    logic [STUCK_W-1:0] stuck_cnt;

    // Rise is registered so a detector edge reaches the counter three clocks after capture
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_1    <= 1'b0;
            sync_2    <= 1'b0;
            sync_prev <= 1'b0;
            rise_q    <= 1'b0;
        end else begin
            sync_1    <= det;
            sync_2    <= sync_1;
            sync_prev <= sync_2;
            rise_q    <= sync_2 & ~sync_prev;
        end
    end

    assign inc         = rise_q && !fault && (cnt != CNT_MAX);
    assign closing_cnt = inc ? cnt + 1'b1 : cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (!active || close) begin
            cnt <= '0;
        end else begin
            cnt <= closing_cnt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stuck_cnt <= '0;
            fault     <= 1'b0;
        end else if (!sync_2) begin
            stuck_cnt <= '0;
            fault     <= 1'b0;
        end else if (stuck_cnt != STUCK_MAX) begin
            stuck_cnt <= stuck_cnt + 1'b1;
            if (stuck_cnt == STUCK_MAX - 1'b1) begin
                fault <= 1'b1;
            end
        end
    end

    // Closing count includes a rise landing in the terminal cycle
    always_comb begin
        level = LVL_LOW;
        if (!fault) begin
            level = quantise(int'(closing_cnt), TH1, TH2, TH3);
        end
    end

endmodule

// File: rtl/traffic_density_sensor.sv
// rtl/traffic_density_sensor.sv - window FSM and registered congestion levels for four approaches
module traffic_density_sensor
    import traffic_pkg::*;
#(
    parameter int WINDOW_CYCLES = 1000,
    parameter int CNT_W         = 8,
    parameter int TH1           = 4,
    parameter int TH2           = 8,
    parameter int TH3           = 16,
    parameter int STUCK_CYCLES  = 500
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       det_a,
    input  logic       det_b,
    input  logic       det_c,
    input  logic       det_d,
    output logic [1:0] Sa,
    output logic [1:0] Sb,
    output logic [1:0] Sc,
    output logic [1:0] Sd,
    output logic       level_valid,
    output logic [3:0] fault
);

    localparam int               WIN_W    = $clog2(WINDOW_CYCLES);
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW_CYCLES - 1);

    state_t           state;
    state_t           state_next;
    logic [WIN_W-1:0] win_cnt;
    logic             active;
    logic             close;
    logic [3:0]       det_all;
    level_t           level [4];

    assign det_all = {det_d, det_c, det_b, det_a};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (en)  state_next = ST_RUN;
            ST_RUN:  if (!en) state_next = ST_IDLE;
        endcase
    end

    // Dropping en on the terminal cycle suppresses the close
    always_comb begin
        active = 1'b0;
        close  = 1'b0;
        if (state == ST_RUN) begin
            active = en;
            close  = en && (win_cnt == WIN_LAST);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            win_cnt <= '0;
        end else if (!active || close) begin
            win_cnt <= '0;
        end else begin
            win_cnt <= win_cnt + 1'b1;
        end
    end

    for (genvar i = 0; i < 4; i++) begin : g_lane
        lane_density_counter #(
            .CNT_W       (CNT_W),
            .TH1         (TH1),
            .TH2         (TH2),
            .TH3         (TH3),
            .STUCK_CYCLES(STUCK_CYCLES)
        ) u_lane (
            .clk   (clk),
            .rst   (rst),
            .det   (det_all[i]),
            .active(active),
            .close (close),
            .level (level[i]),
            .fault (fault[i])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            Sa          <= LVL_LOW;
            Sb          <= LVL_LOW;
            Sc          <= LVL_LOW;
            Sd          <= LVL_LOW;
            level_valid <= 1'b0;
        end else begin
            level_valid <= close;
            if (close) begin
                Sa <= level[0];
                Sb <= level[1];
                Sc <= level[2];
                Sd <= level[3];
            end
        end
    end

endmodule

// File: tb/tb_traffic_density_sensor.sv
// tb/tb_traffic_density_sensor.sv - directed and randomized bench for traffic_density_sensor
module tb_traffic_density_sensor;

    localparam int W     = 20;
    localparam int CNT_W = 8;
    localparam int TH1   = 2;
    localparam int TH2   = 4;
    localparam int TH3   = 6;
    localparam int STUCK = 10;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [3:0] det;
    logic [1:0] sa, sb, sc, sd;
    logic       level_valid;
    logic [3:0] fault;

    int checks = 0;
    int errors = 0;

    traffic_density_sensor #(
        .WINDOW_CYCLES(W),
        .CNT_W        (CNT_W),
        .TH1          (TH1),
        .TH2          (TH2),
        .TH3          (TH3),
        .STUCK_CYCLES (STUCK)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .det_a      (det[0]),
        .det_b      (det[1]),
        .det_c      (det[2]),
        .det_d      (det[3]),
        .Sa         (sa),
        .Sb         (sb),
        .Sc         (sc),
        .Sd         (sd),
        .level_valid(level_valid),
        .fault      (fault)
    );

    always #5 clk = ~clk;

    // Reference: det sampled at edge e rising from e-1 is counted at edge e+3; fault means
    // the detector was sampled high for STUCK consecutive edges ending two edges ago.
    bit       m_h [4][5];
    int       m_cnt [4];
    int       m_run [4];
    bit       m_fault [4];
    bit       m_old_fault [4];
    bit       m_running;
    int       m_pos;
    bit [1:0] m_s [4];
    bit       m_lv;
    int       m_incl;

    function automatic bit [1:0] quant(input int c);
        if (c < TH1) return 2'b00;
        if (c < TH2) return 2'b01;
        if (c < TH3) return 2'b10;
        return 2'b11;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_running = 1'b0;
            m_pos     = 0;
            m_lv      = 1'b0;
            for (int l = 0; l < 4; l++) begin
                m_cnt[l]   = 0;
                m_run[l]   = 0;
                m_fault[l] = 1'b0;
                m_s[l]     = 2'b00;
                for (int k = 0; k < 5; k++) m_h[l][k] = 1'b0;
            end
        end else begin
            m_lv = 1'b0;
            for (int l = 0; l < 4; l++) begin
                m_old_fault[l] = m_fault[l];
                for (int k = 4; k > 0; k--) m_h[l][k] = m_h[l][k-1];
                m_h[l][0]  = det[l];
                m_run[l]   = m_h[l][2] ? m_run[l] + 1 : 0;
                m_fault[l] = (m_run[l] >= STUCK);
            end
            if (m_running && en) begin
                for (int l = 0; l < 4; l++) begin
                    m_incl = m_cnt[l] + ((m_h[l][3] && !m_h[l][4] && !m_old_fault[l]) ? 1 : 0);
                    if (m_incl > 2**CNT_W - 1) m_incl = 2**CNT_W - 1;
                    if (m_pos == W - 1) begin
                        m_s[l]   = m_old_fault[l] ? 2'b00 : quant(m_incl);
                        m_cnt[l] = 0;
                    end else begin
                        m_cnt[l] = m_incl;
                    end
                end
                if (m_pos == W - 1) begin
                    m_lv  = 1'b1;
                    m_pos = 0;
                end else begin
                    m_pos++;
                end
            end else begin
                m_running = en && !m_running;
                m_pos     = 0;
                for (int l = 0; l < 4; l++) m_cnt[l] = 0;
            end
        end
    end

    task automatic idle_gap();
        en  = 1'b0;
        det = 4'b0000;
        repeat (6) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        en  = 1'b0;
        det = 4'b0000;
        repeat (3) @(negedge clk);
        checks++;
        if ({sa, sb, sc, sd, level_valid, fault} !== 13'd0) begin
            errors++;
            $display("FAIL reset_state got %b expected 0", {sa, sb, sc, sd, level_valid, fault});
        end
        rst = 1'b0;
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            checks++;
            if (level_valid !== 1'b0) begin
                errors++;
                $display("FAIL idle_level_valid cycle %0d got %b expected 0", t, level_valid);
            end
        end
        checks++;
        if ({sa, sb, sc, sd, fault} !== 12'd0) begin
            errors++;
            $display("FAIL idle_outputs got %b expected 0", {sa, sb, sc, sd, fault});
        end
    endtask

    task automatic test_quantisation();
        int np [4] = '{1, 3, 5, 7};
        en = 1'b1;
        for (int t = 1; t <= 22; t++) begin
            for (int l = 0; l < 4; l++) det[l] = ((t - 1) % 2 == 0) && ((t - 1) / 2 < np[l]);
            @(negedge clk);
            checks++;
            if (level_valid !== (t == 21)) begin
                errors++;
                $display("FAIL quant_level_valid t=%0d got %b expected %b", t, level_valid, (t == 21));
            end
        end
        checks++;
        if ({sa, sb, sc, sd} !== 8'b00_01_10_11) begin
            errors++;
            $display("FAIL quant_levels got %b expected 00011011", {sa, sb, sc, sd});
        end
        idle_gap();
    endtask

    task automatic test_disable();
        en = 1'b1;
        for (int t = 1; t <= 40; t++) begin
            det[2] = (t == 2 || t == 4 || t == 6);
            en     = (t < 12);
            @(negedge clk);
            checks++;
            if (level_valid !== 1'b0) begin
                errors++;
                $display("FAIL disable_level_valid t=%0d got %b expected 0", t, level_valid);
            end
        end
        checks++;
        if ({sa, sb, sc, sd} !== 8'b00_01_10_11) begin
            errors++;
            $display("FAIL disable_hold got %b expected 00011011", {sa, sb, sc, sd});
        end
        en  = 1'b1;
        det = 4'b0000;
        for (int t = 1; t <= 22; t++) begin
            @(negedge clk);
            checks++;
            if (level_valid !== (t == 21)) begin
                errors++;
                $display("FAIL reenable_level_valid t=%0d got %b expected %b", t, level_valid, (t == 21));
            end
        end
        checks++;
        if ({sa, sb, sc, sd} !== 8'd0) begin
            errors++;
            $display("FAIL reenable_levels got %b expected 0", {sa, sb, sc, sd});
        end
        idle_gap();
    endtask

    task automatic test_terminal_edge();
        en = 1'b1;
        for (int t = 1; t <= 42; t++) begin
            det    = 4'b0000;
            det[0] = (t == 2 || t == 18);
            det[1] = (t == 2 || t == 19 || t == 25);
            @(negedge clk);
            checks++;
            if (level_valid !== (t == 21 || t == 41)) begin
                errors++;
                $display("FAIL term_level_valid t=%0d got %b expected %b", t, level_valid, (t == 21 || t == 41));
            end
            if (t == 21) begin
                checks++;
                if ({sa, sb, sc, sd} !== 8'b01_00_00_00) begin
                    errors++;
                    $display("FAIL term_included got %b expected 01000000", {sa, sb, sc, sd});
                end
            end
            if (t == 41) begin
                checks++;
                if ({sa, sb} !== 4'b00_01) begin
                    errors++;
                    $display("FAIL term_next_window got %b expected 0001", {sa, sb});
                end
            end
        end
        idle_gap();
    endtask

    task automatic test_stuck();
        en = 1'b1;
        for (int t = 1; t <= 42; t++) begin
            det    = 4'b0000;
            det[1] = (t == 2 || t == 4 || t == 6 || (t >= 8 && t <= 24) || t == 30 || t == 32);
            @(negedge clk);
            if (t == 18 || t == 19 || t == 26 || t == 27) begin
                checks++;
                if (fault !== ((t == 19 || t == 26) ? 4'b0010 : 4'b0000)) begin
                    errors++;
                    $display("FAIL stuck_fault t=%0d got %b expected %b", t, fault,
                             (t == 19 || t == 26) ? 4'b0010 : 4'b0000);
                end
            end
            if (t == 21) begin
                checks++;
                if (level_valid !== 1'b1 || sb !== 2'b00) begin
                    errors++;
                    $display("FAIL stuck_forced_low got lv=%b sb=%b expected lv=1 sb=00", level_valid, sb);
                end
            end
            if (t == 41) begin
                checks++;
                if (sb !== 2'b01) begin
                    errors++;
                    $display("FAIL stuck_recovered got %b expected 01", sb);
                end
            end
        end
        idle_gap();
    endtask

    task automatic test_async_reset();
        en     = 1'b0;
        det[0] = 1'b1;
        repeat (14) @(negedge clk);
        en = 1'b1;
        for (int t = 1; t <= 8; t++) begin
            det[2] = (t % 2 == 1);
            @(negedge clk);
        end
        checks++;
        if (fault !== 4'b0001 || sb !== 2'b01) begin
            errors++;
            $display("FAIL async_precondition got fault=%b sb=%b expected fault=0001 sb=01", fault, sb);
        end
        #1 rst = 1'b1;
        #1;
        checks++;
        if ({sa, sb, sc, sd, level_valid, fault} !== 13'd0) begin
            errors++;
            $display("FAIL async_reset_clear got %b expected 0", {sa, sb, sc, sd, level_valid, fault});
        end
        @(negedge clk);
        rst = 1'b0;
        idle_gap();
    endtask

    task automatic test_random();
        int hold [4] = '{0, 0, 0, 0};
        int en_off = 0;
        for (int c = 0; c < 600; c++) begin
            if (en_off > 0) begin
                en = 1'b0;
                en_off--;
            end else begin
                en = 1'b1;
                if ($urandom_range(0, 149) == 0) en_off = $urandom_range(1, 3);
            end
            for (int l = 0; l < 4; l++) begin
                if (hold[l] > 0) begin
                    det[l] = 1'b1;
                    hold[l]--;
                end else if ($urandom_range(0, 99) < 2) begin
                    hold[l] = $urandom_range(8, 16);
                    det[l]  = 1'b1;
                end else begin
                    det[l] = ($urandom_range(0, 2) == 0);
                end
            end
            @(negedge clk);
            checks++;
            if ({sa, sb, sc, sd} !== {m_s[0], m_s[1], m_s[2], m_s[3]} || level_valid !== m_lv ||
                fault !== {m_fault[3], m_fault[2], m_fault[1], m_fault[0]}) begin
                errors++;
                $display("FAIL random_cycle %0d got S=%b lv=%b fault=%b expected S=%b lv=%b fault=%b",
                         c, {sa, sb, sc, sd}, level_valid, fault,
                         {m_s[0], m_s[1], m_s[2], m_s[3]}, m_lv,
                         {m_fault[3], m_fault[2], m_fault[1], m_fault[0]});
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        en  = 1'b0;
        det = 4'b0000;
        test_reset();
        test_quantisation();
        test_disable();
        test_terminal_edge();
        test_stuck();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
